// File: rtl/sysid_checker.sv
// sysid_checker
//   Boot-time Avalon-MM initiator that reads the system ID peripheral
//   (word 0 = system ID, word 1 = build timestamp) and compares both words
//   against compile-time expected values. It reports match, mismatch or
//   a stall timeout.
//
//   Optional feature macro: SYSID_CHECKER_PERIODIC_EN
//     When defined, the block re-runs the check automatically after
//     RECHECK_INTERVAL cycles. The count starts when each check ends.
//     When undefined, checks run only when start is asserted.
//
// Ports
//   clock, reset      rising-edge clock, async active-high reset
//   start             level-sampled request, honoured only when idle
//   avm_address       word address to sysid slave (0 = ID, 1 = timestamp)
//   avm_read          read request, held through stalls
//   avm_readdata      read data from slave
//   avm_waitrequest   slave stall
//   busy              check in progress
//   done              one-cycle pulse when a check ends
//   id_ok, ts_ok      word 0 / word 1 matched expected value
//   timeout           last check aborted on a stall
//   id_value,ts_value captured words
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1683116618,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter int          RECHECK_INTERVAL   = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("sysid_checker: TIMEOUT_CYCLES out of range 1..65535");
  end
  if (RECHECK_INTERVAL < 1) begin : g_bad_interval
    $error("sysid_checker: RECHECK_INTERVAL must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, FIN} state_t;

  // The edge that would push the count to TIMEOUT_CYCLES is the abort edge.
  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] stall_cnt;
  logic        go;

`ifdef SYSID_CHECKER_PERIODIC_EN
  // The interval counter also counts the FIN cycle. That way, a check that
  // is started automatically enters RD_ID RECHECK_INTERVAL cycles after
  // the done pulse. It stays disarmed from reset until the first check ends.
  logic [31:0] ivl_cnt;
  logic        ivl_armed;
  logic        auto_go;

  assign auto_go = ivl_armed && (ivl_cnt >= 32'(RECHECK_INTERVAL - 1));
  assign go      = start || auto_go;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ivl_cnt   <= '0;
      ivl_armed <= 1'b0;
    end else begin
      if (state == FIN) ivl_armed <= 1'b1;
      if (state == IDLE && go)
        ivl_cnt <= '0;
      else if (state == FIN || (state == IDLE && ivl_armed))
        ivl_cnt <= ivl_cnt + 32'd1;
      else
        ivl_cnt <= '0;
    end
  end
`else
  assign go = start;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      stall_cnt   <= '0;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state       <= RD_ID;
            stall_cnt   <= '0;
            avm_read    <= 1'b1;
            avm_address <= 1'b0;
            busy        <= 1'b1;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
          end
        end
        RD_ID: begin
          if (!avm_waitrequest) begin
            id_value    <= avm_readdata;
            id_ok       <= (avm_readdata == EXPECTED_ID);
            state       <= RD_TS;
            stall_cnt   <= '0;
            avm_address <= 1'b1;
          end else if (stall_cnt == STALL_LAST) begin
            timeout  <= 1'b1;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            avm_read <= 1'b0;
            done     <= 1'b1;
            state    <= FIN;
          end else begin
            stall_cnt <= stall_cnt + 16'd1;
          end
        end
        RD_TS: begin
          if (!avm_waitrequest) begin
            ts_value <= avm_readdata;
            ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
            avm_read <= 1'b0;
            done     <= 1'b1;
            state    <= FIN;
          end else if (stall_cnt == STALL_LAST) begin
            // The ID word already captured is kept, but it no longer counts as a pass.
            timeout  <= 1'b1;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            avm_read <= 1'b0;
            done     <= 1'b1;
            state    <= FIN;
          end else begin
            stall_cnt <= stall_cnt + 16'd1;
          end
        end
        FIN: begin
          state       <= IDLE;
          busy        <= 1'b0;
          avm_address <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sysid_checker.md
# sysid_checker

Avalon-MM initiator that reads the system ID peripheral and checks its contents at boot. On `start` it reads word 0 (system ID) and then word 1 (build timestamp), compares each against compile-time expected values, and reports match, mismatch or timeout. It sits beside the Nios II master on the same interconnect and drives the sysid control slave, so software-independent hardware can detect an FPGA image and software build mismatch.

## Interface
Parameters:
- `EXPECTED_ID`, 32'd0, value required at word 0.
- `EXPECTED_TIMESTAMP`, 32'd1683116618, value required at word 1.
- `TIMEOUT_CYCLES`, 255, maximum consecutive `avm_waitrequest` cycles per read; legal range 1..65535.
- `RECHECK_INTERVAL`, 1000000, idle cycles between automatic re-checks; used only with `SYSID_CHECKER_PERIODIC_EN`.

Ports:
- `clock`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  level-sampled request to run one check.
- `avm_address`  out  1  word address to the sysid slave: 0 = ID, 1 = timestamp.
- `avm_read`  out  1  read request.
- `avm_readdata`  in  32  read data, valid when `avm_read` is high and `avm_waitrequest` is low.
- `avm_waitrequest`  in  1  slave stall.
- `busy`  out  1  high while a check is in progress.
- `done`  out  1  one-cycle pulse when a check ends.
- `id_ok`  out  1  word 0 equalled `EXPECTED_ID`.
- `ts_ok`  out  1  word 1 equalled `EXPECTED_TIMESTAMP`.
- `timeout`  out  1  the last check was aborted on a stall.
- `id_value`  out  32  captured word 0.
- `ts_value`  out  32  captured word 1.

## Operation
- FSM states: IDLE, RD_ID, RD_TS, FIN.
- IDLE: `start`=1 at an edge moves the FSM to RD_ID. The same edge clears `id_ok`, `ts_ok`, `timeout`, `id_value` and `ts_value`.
- RD_ID: `avm_read`=1 and `avm_address`=0.
  - On an edge with `avm_waitrequest`=0, capture `avm_readdata` into `id_value`, set `id_ok` = (data == `EXPECTED_ID`), and move to RD_TS.
- RD_TS: `avm_read`=1 and `avm_address`=1.
  - On acceptance, capture `ts_value`, set `ts_ok`, and move to FIN.
- FIN: `done`=1 for exactly one cycle, then return to IDLE.
- Stall counter:
  - Clears on entry to each read state.
  - Increments on each edge in a read state with `avm_waitrequest`=1.
  - When the counter reaches `TIMEOUT_CYCLES`, set `timeout`=1, force `id_ok`=`ts_ok`=0, and go to FIN. Captured values are kept.
- `busy` = 1 in RD_ID, RD_TS and FIN.
- `start` is ignored unless the FSM is in IDLE. `start` held high starts a new check on every IDLE visit.
- `avm_address` is held stable and `avm_read` stays high for the whole of a stalled transfer.
- The `_ok`, `timeout` and `_value` results hold until the next accepted `start` or reset.

## Timing
- Reset (asynchronous) forces:
  - FSM to IDLE.
  - `avm_read`, `avm_address`, `busy`, `done`, `id_ok`, `ts_ok` and `timeout` to 0.
  - `id_value` and `ts_value` to 0.
  - The stall counter and interval counter to 0.
- Reset asserted mid-transfer drops `avm_read` immediately. No partial result is reported.
- All outputs are registered. Nothing combinational passes from `avm_readdata` to any output.
- Zero-wait latency:
  - `start` sampled at edge k.
  - RD_ID occupies cycle k..k+1.
  - RD_TS occupies k+1..k+2.
  - `done` is high in cycle k+2..k+3.
  - Results are valid from edge k+2.
- Each wait cycle on a read adds one cycle of latency.
- Worst-case latency is 2×`TIMEOUT_CYCLES` + 1 cycles.
- Timeout: with `avm_waitrequest` held at 1, `timeout` and `done` rise `TIMEOUT_CYCLES` edges after the read state is entered.

## Configuration
- `SYSID_CHECKER_PERIODIC_EN` defined:
  - After each FIN, an interval counter counts `RECHECK_INTERVAL` cycles in IDLE, then starts a check on its own, exactly as if `start` were asserted.
  - An external `start` during the interval starts a check at once and restarts the interval afterwards.
- `SYSID_CHECKER_PERIODIC_EN` undefined: no interval counter is built, and checks run only on `start`.

## Test plan
- Zero-wait slave returning 0 / 1683116618, `start` pulsed:
  - `avm_read` is high for 2 cycles, at addresses 0 then 1.
  - `done` pulses 3 cycles after `start`.
  - `id_ok`=1, `ts_ok`=1, `timeout`=0.
- Slave timestamp 0x12345678 -> `id_ok`=1, `ts_ok`=0, `ts_value`=0x12345678.
- `avm_waitrequest` held high for 3 cycles on each read -> latency is 9 cycles; address and read stay stable while stalled; results are correct.
- `TIMEOUT_CYCLES`=4, `avm_waitrequest` stuck at 1 -> `done` and `timeout`=1 four edges after RD_ID entry; `id_ok`=`ts_ok`=0; `avm_read`=0 afterwards.
- `reset` asserted during RD_TS -> outputs go to 0 asynchronously. A following `start` then gives a clean pass.
- With `SYSID_CHECKER_PERIODIC_EN`, `RECHECK_INTERVAL`=10 -> a second check starts 10 cycles after the first `done` with no `start` asserted.
